// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp patterns and time width for the intersection scheduler.
package traffic_pkg;

    localparam int TW = 6;

    typedef enum logic [2:0] {
        A_GREEN    = 3'd0,
        A_YELLOW   = 3'd1,
        ALL_RED_AB = 3'd2,
        B_GREEN    = 3'd3,
        B_YELLOW   = 3'd4,
        ALL_RED_BA = 3'd5
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Clamp an 8-bit intermediate sum to the 6-bit display range.
    function automatic logic [TW-1:0] sat(input logic [7:0] v);
        return (v > 8'd63) ? 6'd63 : v[TW-1:0];
    endfunction

endpackage

// File: rtl/sensor_sync.sv
// Two-flop sensor synchronizer plus demand latch for one road.
module sensor_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    input  logic in_green,
    input  logic enter_green,
    output logic synced,
    output logic req
);

    logic s1;

    // Synchronize the sensor; latch demand while not green, clear on entry to green.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            synced <= 1'b0;
            req    <= 1'b0;
        end else begin
            s1     <= sensor;
            synced <= s1;
            if (enter_green)
                req <= 1'b0;
            else if (synced && !in_green)
                req <= 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road right-of-way sequencer with gap-out/max-out green and countdown display.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          tick_1hz,
    input  logic          AS,
    input  logic          BS,
    output logic [2:0]    state,
    output logic [2:0]    a_light,
    output logic [2:0]    b_light,
    output logic [TW-1:0] A_time,
    output logic [TW-1:0] B_time,
    output logic          phase_chg
);

    localparam logic [TW-1:0] GMIN = TW'(GREEN_MIN);
    localparam logic [TW-1:0] YEL  = TW'(YELLOW);
    localparam logic [TW-1:0] AR   = TW'(ALL_RED);
    localparam logic [7:0]    GMAX8 = 8'(GREEN_MAX);
    localparam logic [7:0]    YEL8  = 8'(YELLOW);
    localparam logic [7:0]    AR8   = 8'(ALL_RED);
    localparam logic [7:0]    CYC8  = 8'(GREEN_MIN + YELLOW + ALL_RED);

    logic [2:0]    st, st_n;
    logic [TW-1:0] cnt, cnt_n;
    logic [TW-1:0] el, el_n;
    logic [7:0]    el_inc;
    logic [7:0]    cnt8;
    logic          a_sync, b_sync, a_req, b_req;
    logic          own_sync, other_req;

    sensor_sync u_sync_a (
        .clk         (CLK),
        .rst_n       (RSTn),
        .sensor      (AS),
        .in_green    (st == A_GREEN),
        .enter_green ((st_n == A_GREEN) && (st != A_GREEN)),
        .synced      (a_sync),
        .req         (a_req)
    );

    sensor_sync u_sync_b (
        .clk         (CLK),
        .rst_n       (RSTn),
        .sensor      (BS),
        .in_green    (st == B_GREEN),
        .enter_green ((st_n == B_GREEN) && (st != B_GREEN)),
        .synced      (b_sync),
        .req         (b_req)
    );

    // Phase, countdown, green-elapsed and change-pulse registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            st        <= ALL_RED_BA;
            cnt       <= AR;
            el        <= '0;
            phase_chg <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            el        <= el_n;
            phase_chg <= (st_n != st);
        end
    end

    // Next-state: only ticks advance time; illegal codes recover to all-red.
    always_comb begin
        st_n      = st;
        cnt_n     = cnt;
        el_n      = el;
        el_inc    = ({2'b00, el} >= GMAX8) ? GMAX8 : ({2'b00, el} + 8'd1);
        own_sync  = (st == A_GREEN) ? a_sync : b_sync;
        other_req = (st == A_GREEN) ? b_req  : a_req;
        case (st)
            A_GREEN, B_GREEN: if (tick_1hz) begin
                el_n = el_inc[TW-1:0];
                if (cnt > 6'd1)
                    cnt_n = cnt - 6'd1;
                else if (other_req && (!own_sync || el_inc >= GMAX8)) begin
                    st_n  = (st == A_GREEN) ? A_YELLOW : B_YELLOW;
                    cnt_n = YEL;
                end
            end
            A_YELLOW, B_YELLOW: if (tick_1hz) begin
                if (cnt > 6'd1)
                    cnt_n = cnt - 6'd1;
                else begin
                    st_n  = (st == A_YELLOW) ? ALL_RED_AB : ALL_RED_BA;
                    cnt_n = AR;
                end
            end
            ALL_RED_AB, ALL_RED_BA: if (tick_1hz) begin
                if (cnt > 6'd1)
                    cnt_n = cnt - 6'd1;
                else begin
                    st_n  = (st == ALL_RED_AB) ? B_GREEN : A_GREEN;
                    cnt_n = GMIN;
                    el_n  = '0;
                end
            end
            default: begin
                st_n  = ALL_RED_BA;
                cnt_n = AR;
            end
        endcase
    end

    // Lamp and countdown decode straight from the registers.
    always_comb begin
        cnt8    = {2'b00, cnt};
        state   = st;
        a_light = LAMP_R;
        b_light = LAMP_R;
        A_time  = cnt;
        B_time  = sat(cnt8 + CYC8);
        case (st)
            A_GREEN: begin
                a_light = LAMP_G;
                B_time  = sat(cnt8 + YEL8 + AR8);
            end
            A_YELLOW: begin
                a_light = LAMP_Y;
                B_time  = sat(cnt8 + AR8);
            end
            ALL_RED_AB: begin
                B_time = cnt;
                A_time = sat(cnt8 + CYC8);
            end
            B_GREEN: begin
                b_light = LAMP_G;
                B_time  = cnt;
                A_time  = sat(cnt8 + YEL8 + AR8);
            end
            B_YELLOW: begin
                b_light = LAMP_Y;
                B_time  = cnt;
                A_time  = sat(cnt8 + AR8);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for the intersection scheduler with hand-computed expectations.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       AS = 1'b0;
    logic       BS = 1'b0;
    logic [2:0] state, a_light, b_light;
    logic [5:0] A_time, B_time;
    logic       phase_chg;

    int checks = 0;
    int errors = 0;
    int pc_cnt = 0;

    always #10 CLK = ~CLK;

    traffic_phase_scheduler dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .tick_1hz  (tick_1hz),
        .AS        (AS),
        .BS        (BS),
        .state     (state),
        .a_light   (a_light),
        .b_light   (b_light),
        .A_time    (A_time),
        .B_time    (B_time),
        .phase_chg (phase_chg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each tick is one clean cycle; phase_chg is sampled in the cycle after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            tick_1hz = 1'b1;
            @(negedge CLK);
            tick_1hz = 1'b0;
            if (phase_chg) pc_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        tick_1hz = 1'b0;
        AS = 1'b0;
        BS = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        pc_cnt = 0;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_state", state, 5);
        chk("rst_alight", a_light, 3'b100);
        chk("rst_blight", b_light, 3'b100);
        chk("rst_atime", A_time, 2);
        chk("rst_btime", B_time, 17);
        chk("rst_pchg", phase_chg, 0);

        // No sensors: enter A_GREEN, then rest in green
        tick(2);
        chk("s1_state", state, 0);
        chk("s1_alight", a_light, 3'b001);
        chk("s1_blight", b_light, 3'b100);
        chk("s1_atime", A_time, 10);
        chk("s1_btime", B_time, 15);
        chk("s1_pchg", pc_cnt, 1);
        tick(20);
        chk("s1_rest_state", state, 0);
        chk("s1_rest_atime", A_time, 1);

        // BS one-cycle pulse at second 3 of A_GREEN: gap-out after 10 ticks
        do_reset();
        tick(2);
        pc_cnt = 0;
        tick(2);
        @(negedge CLK); BS = 1'b1;
        @(negedge CLK); BS = 1'b0;
        tick(7);
        chk("s2_g9_state", state, 0);
        chk("s2_g9_atime", A_time, 1);
        tick(1);
        chk("s2_y_state", state, 1);
        chk("s2_y_alight", a_light, 3'b010);
        chk("s2_y_atime3", A_time, 3);
        chk("s2_y_btime", B_time, 5);
        tick(1);
        chk("s2_y_atime2", A_time, 2);
        tick(1);
        chk("s2_y_atime1", A_time, 1);
        tick(1);
        chk("s2_ar_state", state, 2);
        chk("s2_ar_btime", B_time, 2);
        chk("s2_ar_atime", A_time, 17);
        tick(1);
        chk("s2_ar1_state", state, 2);
        tick(1);
        chk("s2_bg_state", state, 3);
        chk("s2_bg_blight", b_light, 3'b001);
        chk("s2_bg_alight", a_light, 3'b100);
        chk("s2_bg_btime", B_time, 10);
        chk("s2_bg_atime", A_time, 15);
        chk("s2_pchg_cnt", pc_cnt, 3);

        // Both sensors held: max-out at 30 on each road
        do_reset();
        AS = 1'b1; BS = 1'b1;
        tick(2);
        tick(29);
        chk("s3_a29_state", state, 0);
        tick(1);
        chk("s3_a30_state", state, 1);
        tick(5);
        chk("s3_bg_state", state, 3);
        chk("s3_bg_btime", B_time, 10);
        tick(29);
        chk("s3_b29_state", state, 3);
        tick(1);
        chk("s3_b30_state", state, 4);

        // AS drops 5 cycles before tick 16 of A_GREEN with BS demand
        do_reset();
        AS = 1'b1; BS = 1'b1;
        tick(2);
        tick(15);
        chk("s4_g15_state", state, 0);
        AS = 1'b0;
        repeat (4) @(negedge CLK);
        tick(1);
        chk("s4_g16_state", state, 1);
        chk("s4_g16_atime", A_time, 3);

        // Drive into B_YELLOW with cnt=2, then asynchronous reset pulse
        BS = 1'b0; AS = 1'b1;
        tick(5);
        chk("s5_bg_state", state, 3);
        chk("s5_bg_btime", B_time, 10);
        tick(10);
        chk("s5_by_state", state, 4);
        chk("s5_by_btime3", B_time, 3);
        tick(1);
        chk("s5_by_btime2", B_time, 2);
        chk("s5_by_atime", A_time, 4);
        chk("s5_areq_pre", dut.a_req, 1);
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        chk("s5_rst_state", state, 5);
        chk("s5_rst_alight", a_light, 3'b100);
        chk("s5_rst_blight", b_light, 3'b100);
        chk("s5_rst_atime", A_time, 2);
        chk("s5_rst_btime", B_time, 17);
        chk("s5_rst_areq", dut.a_req, 0);
        chk("s5_rst_breq", dut.b_req, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        AS = 1'b0;
        tick(2);
        chk("s5_resume_state", state, 0);
        chk("s5_resume_atime", A_time, 10);

        // Illegal state recovery, then a multi-cycle tick in A_YELLOW
        @(negedge CLK);
        force dut.st = 3'd7;
        #1;
        chk("s6_forced", state, 7);
        #1;
        release dut.st;
        @(negedge CLK);
        chk("s6_rec_state", state, 5);
        chk("s6_rec_cnt", dut.cnt, 2);
        chk("s6_rec_atime", A_time, 2);
        @(negedge CLK); BS = 1'b1;
        @(negedge CLK); BS = 1'b0;
        tick(2);
        chk("s6_ag_state", state, 0);
        tick(10);
        chk("s6_ay_state", state, 1);
        chk("s6_ay_atime", A_time, 3);
        @(negedge CLK);
        tick_1hz = 1'b1;
        repeat (3) @(negedge CLK);
        tick_1hz = 1'b0;
        chk("s6_hold_state", state, 2);
        chk("s6_hold_btime", B_time, 2);
        chk("s6_hold_atime", A_time, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
